sort_ctrl: RTL

//  Packet-level initiator for the bubble-sorter core: accepts one Avalon-ST packet of words,

---
 rtl/sort_pkg.sv | 26 ++
 rtl/sort_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sort_pkg.sv
// Types and command encodings shared by sort_ctrl and the bubble-sorter core.
// Commands are one-hot-ish {sort,output,clear} triples, one per cycle.
package sort_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_UNLOAD
  } state_t;

  typedef struct packed {
    logic sort_op;
    logic output_op;
    logic clear_op;
  } sorter_cmd_t;

  localparam sorter_cmd_t CMD_NOP   = '{sort_op: 1'b0, output_op: 1'b0, clear_op: 1'b0};
  localparam sorter_cmd_t CMD_WRITE = '{sort_op: 1'b1, output_op: 1'b0, clear_op: 1'b0};
  localparam sorter_cmd_t CMD_START = '{sort_op: 1'b1, output_op: 1'b1, clear_op: 1'b0};
  localparam sorter_cmd_t CMD_READ  = '{sort_op: 1'b0, output_op: 1'b1, clear_op: 1'b0};
  localparam sorter_cmd_t CMD_CLEAR = '{sort_op: 1'b0, output_op: 1'b0, clear_op: 1'b1};

endpackage

// File: rtl/sort_ctrl.sv
// Packet loader/unloader for the bubble sorter: WRITE words, START, wait for done, READ back as a stream.
// Commands registered (eop -> START 2 cycles, done -> first src word 2 cycles); sink stalled outside LOAD, source never stalls.
module sort_ctrl
  import sort_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              srst_i,

  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,

  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,

  output logic              sort_op_o,
  output logic              output_op_o,
  output logic              clear_op_o,
  output logic [AWIDTH-1:0] cntr_o,
  output logic [DWIDTH-1:0] data_o,
  input  logic              sort_done_i,
  input  logic [DWIDTH-1:0] data_i
);

  localparam int              MAXLEN   = 2 ** AWIDTH;
  localparam logic [AWIDTH:0] MAXLEN_L = (AWIDTH + 1)'(MAXLEN);
  localparam logic [AWIDTH:0] ONE_L    = (AWIDTH + 1)'(1);

  state_t              state_q, state_d;
  sorter_cmd_t         cmd_q, cmd_d;
  logic [AWIDTH-1:0]   cntr_q, cntr_d;
  logic [DWIDTH-1:0]   wdat_q, wdat_d;
  logic [AWIDTH:0]     idx_q, idx_d;
  logic [AWIDTH:0]     len_q, len_d;
  logic [AWIDTH:0]     rd_idx_q, rd_idx_d;
  logic                in_pkt_q, in_pkt_d;
  logic                ready_q;
  logic                src_vld_q, src_sop_q, src_eop_q;
  logic                accept;
  logic [AWIDTH-1:0]   len_m1;

  assign accept = snk_valid_i & ready_q;
  assign len_m1 = AWIDTH'(len_q - ONE_L);

  always_comb begin
    state_d  = state_q;
    cmd_d    = CMD_NOP;
    cntr_d   = '0;
    wdat_d   = '0;
    idx_d    = idx_q;
    len_d    = len_q;
    rd_idx_d = rd_idx_q;
    in_pkt_d = in_pkt_q;

    case (state_q)
      ST_IDLE: state_d = ST_CLEAR;

      ST_CLEAR: begin
        cmd_d    = CMD_CLEAR;
        idx_d    = '0;
        len_d    = '0;
        in_pkt_d = 1'b0;
        state_d  = ST_LOAD;
      end

      ST_LOAD: begin
        if (accept) begin
          if (snk_startofpacket_i) begin
            // sop always (re)starts the packet at index 0
            cmd_d    = CMD_WRITE;
            wdat_d   = snk_data_i;
            idx_d    = ONE_L;
            in_pkt_d = 1'b1;
            if (snk_endofpacket_i) begin
              len_d    = ONE_L;
              rd_idx_d = '0;
              state_d  = ST_UNLOAD;
            end
          end else if (in_pkt_q) begin
            if (idx_q < MAXLEN_L) begin
              cmd_d  = CMD_WRITE;
              cntr_d = idx_q[AWIDTH-1:0];
              wdat_d = snk_data_i;
              idx_d  = idx_q + ONE_L;
            end
            // Past MAXLEN words are dropped; length saturates
            if (snk_endofpacket_i) begin
              len_d   = (idx_q < MAXLEN_L) ? idx_q + ONE_L : MAXLEN_L;
              state_d = ST_START;
            end
          end
        end
      end

      ST_START: begin
        cmd_d   = CMD_START;
        cntr_d  = len_m1;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (sort_done_i) begin
          cmd_d    = CMD_READ;
          rd_idx_d = ONE_L;
          state_d  = ST_UNLOAD;
        end
      end

      ST_UNLOAD: begin
        cmd_d    = CMD_READ;
        cntr_d   = rd_idx_q[AWIDTH-1:0];
        rd_idx_d = rd_idx_q + ONE_L;
        if (rd_idx_q + ONE_L == len_q) state_d = ST_CLEAR;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= ST_IDLE;
      cmd_q     <= CMD_NOP;
      cntr_q    <= '0;
      wdat_q    <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      rd_idx_q  <= '0;
      in_pkt_q  <= 1'b0;
      ready_q   <= 1'b0;
      src_vld_q <= 1'b0;
      src_sop_q <= 1'b0;
      src_eop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cntr_q    <= cntr_d;
      wdat_q    <= wdat_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      rd_idx_q  <= rd_idx_d;
      in_pkt_q  <= in_pkt_d;
      ready_q   <= (state_d == ST_LOAD);
      // Sorter returns read data one cycle after the READ command
      src_vld_q <= (cmd_q == CMD_READ);
      src_sop_q <= (cmd_q == CMD_READ) && (cntr_q == '0);
      src_eop_q <= (cmd_q == CMD_READ) && (cntr_q == len_m1);
    end
  end

  assign snk_ready_o         = ready_q;
  assign src_valid_o         = src_vld_q;
  assign src_startofpacket_o = src_sop_q;
  assign src_endofpacket_o   = src_eop_q;
  assign src_data_o          = src_vld_q ? data_i : '0;
  assign sort_op_o           = cmd_q.sort_op;
  assign output_op_o         = cmd_q.output_op;
  assign clear_op_o          = cmd_q.clear_op;
  assign cntr_o              = cntr_q;
  assign data_o              = wdat_q;

endmodule
